// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter: request/address/data out,
// grant and read response back.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port data memory: zero-latency grant,
// read response routed back one cycle later, contention cycle counter.
module dmem_arbiter #(
    parameter int ADDR_W        = 32,
    parameter int DATA_W        = 32,
    parameter int PRIORITY_MODE = 0,
    parameter int STARVE_LIMIT  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);
    localparam logic [7:0] STARVE_MAX = 8'(STARVE_LIMIT);

    logic        r_resp_pending;
    logic        r_resp_id;
    logic        r_last_grant;
    logic [7:0]  r_starve_cnt;
    logic [15:0] r_conflict_cnt;

    logic w_both;
    logic w_pick1;
    logic w_gnt0;
    logic w_gnt1;

    assign w_both = m0.req & m1.req;

    // w_pick1 only matters on a tie; it says which side wins it.
    generate
        if (PRIORITY_MODE == 0) begin : g_round_robin
            assign w_pick1 = ~r_last_grant;
        end else begin : g_fixed
            assign w_pick1 = (r_starve_cnt == STARVE_MAX);
        end
    endgenerate

    assign w_gnt0 = rst_n & m0.req & ~(m1.req &  w_pick1);
    assign w_gnt1 = rst_n & m1.req & ~(m0.req & ~w_pick1);

    assign m0.gnt = w_gnt0;
    assign m1.gnt = w_gnt1;

    assign mem_en    = w_gnt0 | w_gnt1;
    assign mem_we    = w_gnt1 ? m1.we    : (w_gnt0 & m0.we);
    assign mem_addr  = w_gnt1 ? m1.addr  : m0.addr;
    assign mem_wdata = w_gnt1 ? m1.wdata : m0.wdata;

    // Gating with rst_n drops a response whose read was accepted just before reset.
    assign m0.rvalid = rst_n & r_resp_pending & ~r_resp_id;
    assign m1.rvalid = rst_n & r_resp_pending &  r_resp_id;
    assign m0.rdata  = mem_rdata;
    assign m1.rdata  = mem_rdata;

    assign conflict_cnt = r_conflict_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp_pending <= 1'b0;
            r_resp_id      <= 1'b0;
            r_last_grant   <= 1'b1;
            r_starve_cnt   <= 8'd0;
            r_conflict_cnt <= 16'd0;
        end else begin
            r_resp_pending <= (w_gnt0 & ~m0.we) | (w_gnt1 & ~m1.we);
            r_resp_id      <= w_gnt1;
            if (w_gnt0 | w_gnt1) begin
                r_last_grant <= w_gnt1;
            end
            if (!m1.req || w_gnt1) begin
                r_starve_cnt <= 8'd0;
            end else if (r_starve_cnt != STARVE_MAX) begin
                r_starve_cnt <= r_starve_cnt + 8'd1;
            end
            if (w_both && r_conflict_cnt != 16'hFFFF) begin
                r_conflict_cnt <= r_conflict_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance and a fixed-priority
// instance (STARVE_LIMIT=3), each with its own word-addressed memory model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rr_m0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) rr_m1 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fx_m0 ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) fx_m1 ();

    logic          rr_mem_en, rr_mem_we, fx_mem_en, fx_mem_we;
    logic [AW-1:0] rr_mem_addr, fx_mem_addr;
    logic [DW-1:0] rr_mem_wdata, rr_mem_rdata, fx_mem_wdata, fx_mem_rdata;
    logic [15:0]   rr_conflict, fx_conflict;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(0), .STARVE_LIMIT(8)) dut_rr (
        .clk(clk), .rst_n(rst_n), .m0(rr_m0.slave), .m1(rr_m1.slave),
        .mem_en(rr_mem_en), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata), .conflict_cnt(rr_conflict)
    );

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .PRIORITY_MODE(1), .STARVE_LIMIT(3)) dut_fx (
        .clk(clk), .rst_n(rst_n), .m0(fx_m0.slave), .m1(fx_m1.slave),
        .mem_en(fx_mem_en), .mem_we(fx_mem_we), .mem_addr(fx_mem_addr),
        .mem_wdata(fx_mem_wdata), .mem_rdata(fx_mem_rdata), .conflict_cnt(fx_conflict)
    );

    logic [DW-1:0] rr_mem [4096];
    logic [DW-1:0] fx_mem [4096];

    always @(posedge clk) begin
        if (rr_mem_en) begin
            if (rr_mem_we) rr_mem[rr_mem_addr[13:2]] = rr_mem_wdata;
            else           rr_mem_rdata <= rr_mem[rr_mem_addr[13:2]];
        end
    end

    always @(posedge clk) begin
        if (fx_mem_en) begin
            if (fx_mem_we) fx_mem[fx_mem_addr[13:2]] = fx_mem_wdata;
            else           fx_mem_rdata <= fx_mem[fx_mem_addr[13:2]];
        end
    end

    int checks   = 0;
    int failures = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        rr_m0.req = 0; rr_m0.we = 0; rr_m0.addr = '0; rr_m0.wdata = '0;
        rr_m1.req = 0; rr_m1.we = 0; rr_m1.addr = '0; rr_m1.wdata = '0;
        fx_m0.req = 0; fx_m0.we = 0; fx_m0.addr = '0; fx_m0.wdata = '0;
        fx_m1.req = 0; fx_m1.we = 0; fx_m1.addr = '0; fx_m1.wdata = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rr_m0.req = 1; rr_m1.req = 1; rr_m1.we = 1;
        fx_m0.req = 1; fx_m1.req = 1;
        tick();
        @(negedge clk);
        $display("[reset] rr g0=%b g1=%b en=%b we=%b fx g0=%b g1=%b", rr_m0.gnt, rr_m1.gnt,
                 rr_mem_en, rr_mem_we, fx_m0.gnt, fx_m1.gnt);
        checks++; if ({rr_m0.gnt, rr_m1.gnt} !== 2'b00) begin failures++; $display("FAIL reset_rr_gnt got=%b exp=00", {rr_m0.gnt, rr_m1.gnt}); end
        checks++; if ({rr_mem_en, rr_mem_we} !== 2'b00) begin failures++; $display("FAIL reset_rr_mem_en_we got=%b exp=00", {rr_mem_en, rr_mem_we}); end
        checks++; if ({fx_m0.gnt, fx_m1.gnt, fx_mem_en} !== 3'b000) begin failures++; $display("FAIL reset_fx_gnt_en got=%b exp=000", {fx_m0.gnt, fx_m1.gnt, fx_mem_en}); end
        checks++; if ({rr_m0.rvalid, rr_m1.rvalid} !== 2'b00) begin failures++; $display("FAIL reset_rr_rvalid got=%b exp=00", {rr_m0.rvalid, rr_m1.rvalid}); end
        checks++; if (rr_conflict !== 16'd0) begin failures++; $display("FAIL reset_conflict got=%h exp=0000", rr_conflict); end
        idle_all();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_read();
        rr_m0.req = 1; rr_m0.we = 0; rr_m0.addr = 32'h10;
        @(negedge clk);
        $display("[single_read] g0=%b en=%b addr=%h", rr_m0.gnt, rr_mem_en, rr_mem_addr);
        checks++; if ({rr_m0.gnt, rr_m1.gnt, rr_mem_en, rr_mem_we} !== 4'b1010) begin failures++; $display("FAIL single_read_gnt got=%b exp=1010", {rr_m0.gnt, rr_m1.gnt, rr_mem_en, rr_mem_we}); end
        checks++; if (rr_mem_addr !== 32'h10) begin failures++; $display("FAIL single_read_addr got=%h exp=00000010", rr_mem_addr); end
        tick();
        rr_m0.req = 0;
        @(negedge clk);
        $display("[single_read] rvalid0=%b rvalid1=%b rdata=%h", rr_m0.rvalid, rr_m1.rvalid, rr_m0.rdata);
        checks++; if ({rr_m0.rvalid, rr_m1.rvalid} !== 2'b10) begin failures++; $display("FAIL single_read_rvalid got=%b exp=10", {rr_m0.rvalid, rr_m1.rvalid}); end
        checks++; if (rr_m0.rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_read_rdata got=%h exp=deadbeef", rr_m0.rdata); end
        tick();
    endtask

    task automatic test_rr_alternate();
        logic [5:0] exp_g0;
        exp_g0 = 6'b010101;  // bit i: m0 granted in cycle i
        apply_reset();
        rr_m0.req = 1; rr_m0.we = 0; rr_m0.addr = 32'h20;
        rr_m1.req = 1; rr_m1.we = 0; rr_m1.addr = 32'h24;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            $display("[rr] cycle %0d g0=%b g1=%b rv0=%b rv1=%b", i, rr_m0.gnt, rr_m1.gnt, rr_m0.rvalid, rr_m1.rvalid);
            checks++; if ({rr_m0.gnt, rr_m1.gnt} !== {exp_g0[i], ~exp_g0[i]}) begin failures++; $display("FAIL rr_gnt cycle=%0d got=%b exp=%b", i, {rr_m0.gnt, rr_m1.gnt}, {exp_g0[i], ~exp_g0[i]}); end
            if (i > 0) begin
                checks++; if ({rr_m0.rvalid, rr_m1.rvalid} !== {exp_g0[i-1], ~exp_g0[i-1]}) begin failures++; $display("FAIL rr_rvalid cycle=%0d got=%b exp=%b", i, {rr_m0.rvalid, rr_m1.rvalid}, {exp_g0[i-1], ~exp_g0[i-1]}); end
                checks++; if (rr_m0.rdata !== (exp_g0[i-1] ? 32'hA0A0A0A0 : 32'hB1B1B1B1)) begin failures++; $display("FAIL rr_rdata cycle=%0d got=%h", i, rr_m0.rdata); end
            end
            tick();
        end
        rr_m0.req = 0; rr_m1.req = 0;
        @(negedge clk);
        $display("[rr] tail rv0=%b rv1=%b conflict=%0d", rr_m0.rvalid, rr_m1.rvalid, rr_conflict);
        checks++; if ({rr_m0.rvalid, rr_m1.rvalid} !== 2'b01) begin failures++; $display("FAIL rr_last_rvalid got=%b exp=01", {rr_m0.rvalid, rr_m1.rvalid}); end
        checks++; if (rr_m1.rdata !== 32'hB1B1B1B1) begin failures++; $display("FAIL rr_last_rdata got=%h exp=b1b1b1b1", rr_m1.rdata); end
        checks++; if (rr_conflict !== 16'd6) begin failures++; $display("FAIL rr_conflict got=%0d exp=6", rr_conflict); end
        tick();
    endtask

    task automatic test_fixed_starve();
        logic [7:0] exp_g1;
        exp_g1 = 8'b1000_1000;  // bit i: m1 force-granted in cycle i
        apply_reset();
        fx_m0.req = 1; fx_m0.we = 0; fx_m0.addr = 32'h20;
        fx_m1.req = 1; fx_m1.we = 0; fx_m1.addr = 32'h24;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            $display("[fixed] cycle %0d g0=%b g1=%b", i, fx_m0.gnt, fx_m1.gnt);
            checks++; if ({fx_m0.gnt, fx_m1.gnt} !== {~exp_g1[i], exp_g1[i]}) begin failures++; $display("FAIL fixed_gnt cycle=%0d got=%b exp=%b", i, {fx_m0.gnt, fx_m1.gnt}, {~exp_g1[i], exp_g1[i]}); end
            tick();
        end
        fx_m0.req = 0; fx_m1.req = 0;
        @(negedge clk);
        checks++; if (fx_conflict !== 16'd8) begin failures++; $display("FAIL fixed_conflict got=%0d exp=8", fx_conflict); end
        tick();
    endtask

    task automatic test_write_then_read();
        rr_m1.req = 1; rr_m1.we = 1; rr_m1.addr = 32'h40; rr_m1.wdata = 32'h12345678;
        @(negedge clk);
        $display("[wr] g1=%b we=%b addr=%h wdata=%h", rr_m1.gnt, rr_mem_we, rr_mem_addr, rr_mem_wdata);
        checks++; if ({rr_m1.gnt, rr_mem_en, rr_mem_we} !== 3'b111) begin failures++; $display("FAIL wr_gnt_we got=%b exp=111", {rr_m1.gnt, rr_mem_en, rr_mem_we}); end
        checks++; if ({rr_mem_addr, rr_mem_wdata} !== {32'h40, 32'h12345678}) begin failures++; $display("FAIL wr_addr_data got=%h_%h exp=00000040_12345678", rr_mem_addr, rr_mem_wdata); end
        tick();
        rr_m1.req = 0; rr_m1.we = 0;
        rr_m0.req = 1; rr_m0.we = 0; rr_m0.addr = 32'h40;
        @(negedge clk);
        $display("[rd] g0=%b we=%b rv0=%b rv1=%b", rr_m0.gnt, rr_mem_we, rr_m0.rvalid, rr_m1.rvalid);
        checks++; if ({rr_m0.gnt, rr_mem_we} !== 2'b10) begin failures++; $display("FAIL rd_gnt_we got=%b exp=10", {rr_m0.gnt, rr_mem_we}); end
        checks++; if ({rr_m0.rvalid, rr_m1.rvalid} !== 2'b00) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=00", {rr_m0.rvalid, rr_m1.rvalid}); end
        tick();
        rr_m0.req = 0;
        @(negedge clk);
        $display("[rd] rv0=%b rdata=%h", rr_m0.rvalid, rr_m0.rdata);
        checks++; if ({rr_m0.rvalid, rr_m0.rdata} !== {1'b1, 32'h12345678}) begin failures++; $display("FAIL rd_data got=%b_%h exp=1_12345678", rr_m0.rvalid, rr_m0.rdata); end
        tick();
    endtask

    task automatic test_reset_mid_read();
        rr_m0.req = 1; rr_m0.we = 0; rr_m0.addr = 32'h10;
        @(negedge clk);
        checks++; if (rr_m0.gnt !== 1'b1) begin failures++; $display("FAIL midrst_gnt got=%b exp=1", rr_m0.gnt); end
        tick();
        rst_n = 1'b0;
        rr_m1.req = 1;
        @(negedge clk);
        $display("[midrst] rv0=%b g0=%b g1=%b en=%b", rr_m0.rvalid, rr_m0.gnt, rr_m1.gnt, rr_mem_en);
        checks++; if (rr_m0.rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%b exp=0", rr_m0.rvalid); end
        checks++; if ({rr_m0.gnt, rr_m1.gnt, rr_mem_en} !== 3'b000) begin failures++; $display("FAIL midrst_gnt_en got=%b exp=000", {rr_m0.gnt, rr_m1.gnt, rr_mem_en}); end
        tick();
        @(negedge clk);
        checks++; if ({rr_m0.rvalid, rr_conflict} !== {1'b0, 16'd0}) begin failures++; $display("FAIL midrst_after got=%b_%h exp=0_0000", rr_m0.rvalid, rr_conflict); end
        idle_all();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_conflict_saturate();
        apply_reset();
        rr_m0.req = 1; rr_m1.req = 1;
        repeat (65534) @(posedge clk);
        #1;
        @(negedge clk);
        $display("[sat] conflict=%h after 65534 contended cycles", rr_conflict);
        checks++; if (rr_conflict !== 16'hFFFE) begin failures++; $display("FAIL sat_pre got=%h exp=fffe", rr_conflict); end
        tick(); tick(); tick();
        @(negedge clk);
        $display("[sat] conflict=%h after 3 more", rr_conflict);
        checks++; if (rr_conflict !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h exp=ffff", rr_conflict); end
        idle_all();
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        idle_all();
        rr_mem[4] = 32'hDEADBEEF;
        rr_mem[8] = 32'hA0A0A0A0;
        rr_mem[9] = 32'hB1B1B1B1;
        fx_mem[8] = 32'hA0A0A0A0;
        fx_mem[9] = 32'hB1B1B1B1;
        tick();
        test_reset();
        test_single_read();
        test_rr_alternate();
        test_fixed_starve();
        test_write_then_read();
        test_reset_mid_read();
        test_conflict_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
